// File: rtl/despacho_pkg.sv
// despacho_pkg: opcodes, issue-class encodings and dispatcher FSM states
package despacho_pkg;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_ST  = 4'h4;
  localparam logic [1:0] CLS_ADD  = 2'd0;
  localparam logic [1:0] CLS_MUL  = 2'd1;
  localparam logic [1:0] CLS_MEM  = 2'd2;
  localparam logic [1:0] CLS_NONE = 2'd3;
  typedef enum logic {IDLE, HOLD} state_t;
  function automatic logic [1:0] op_class(input logic [3:0] op);
    return (op == OP_ADD || op == OP_SUB) ? CLS_ADD :
           (op == OP_MUL) ? CLS_MUL :
           (op == OP_LD || op == OP_ST) ? CLS_MEM : CLS_NONE;
  endfunction
endpackage

// File: rtl/unidade_despacho_prio_enc_lsb.sv
// prio_enc_lsb: one-hot of the lowest set bit of v, plus an any-set flag
module prio_enc_lsb #(
  parameter int W = 4
) (
  input  logic [W-1:0] v,
  output logic [W-1:0] onehot,
  output logic         any
);
  assign onehot = v & (~v + W'(1));
  assign any = |v;
endmodule

// File: rtl/unidade_despacho.sv
// unidade_despacho: in-order issue from the instruction queue into class-matched reservation stations
module unidade_despacho
  import despacho_pkg::*;
#(
  parameter int N_RS_ADD = 3,
  parameter int N_RS_MUL = 2,
  parameter int N_RS_MEM = 2,
  parameter int W_INSTR  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               empty,
  input  logic [W_INSTR-1:0] instrucao_fila,
  output logic               pop,
  input  logic [N_RS_ADD-1:0] busy_add,
  input  logic [N_RS_MUL-1:0] busy_mul,
  input  logic [N_RS_MEM-1:0] busy_mem,
  output logic               issue_valid,
  output logic [1:0]         issue_class,
  output logic [3:0]         issue_sel,
  output logic [W_INSTR-1:0] issue_instr,
  output logic               invalid_op,
  output logic [15:0]        issued_count
);
  state_t state;
  logic [W_INSTR-1:0] ir;
  logic [1:0] cls, last_cls;
  logic [3:0] last_sel, sel;
  logic [N_RS_ADD-1:0] free_add, sel_add;
  logic [N_RS_MUL-1:0] free_mul, sel_mul;
  logic [N_RS_MEM-1:0] free_mem, sel_mem;
  logic any_add, any_mul, any_mem, any, in_hold, undef, done;
  assign cls = op_class(ir[W_INSTR-1 -: 4]);
  // the entry issued last cycle is not yet marked busy by the RS, so mask it here
  assign free_add = ~busy_add & ~(last_cls == CLS_ADD ? last_sel[N_RS_ADD-1:0] : '0);
  assign free_mul = ~busy_mul & ~(last_cls == CLS_MUL ? last_sel[N_RS_MUL-1:0] : '0);
  assign free_mem = ~busy_mem & ~(last_cls == CLS_MEM ? last_sel[N_RS_MEM-1:0] : '0);
  prio_enc_lsb #(.W(N_RS_ADD)) u_enc_add (.v(free_add), .onehot(sel_add), .any(any_add));
  prio_enc_lsb #(.W(N_RS_MUL)) u_enc_mul (.v(free_mul), .onehot(sel_mul), .any(any_mul));
  prio_enc_lsb #(.W(N_RS_MEM)) u_enc_mem (.v(free_mem), .onehot(sel_mem), .any(any_mem));
  always_comb begin
    any = cls == CLS_ADD ? any_add : cls == CLS_MUL ? any_mul : cls == CLS_MEM ? any_mem : 1'b0;
    sel = cls == CLS_ADD ? 4'(sel_add) : cls == CLS_MUL ? 4'(sel_mul) : cls == CLS_MEM ? 4'(sel_mem) : 4'd0;
    in_hold = state == HOLD && !flush;
    undef = in_hold && cls == CLS_NONE;
    issue_valid = in_hold && any;
    done = issue_valid || undef;
    pop = rst_n && !empty && !flush && (state == IDLE || done);
    issue_sel = issue_valid ? sel : 4'd0;
    issue_class = cls;
    issue_instr = ir;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ir <= '0;
      last_cls <= CLS_NONE;
      last_sel <= '0;
      invalid_op <= 1'b0;
      issued_count <= '0;
    end else begin
      last_cls <= cls;
      last_sel <= issue_sel;
      if (issue_valid) issued_count <= issued_count + 16'd1;
      if (undef) invalid_op <= 1'b1;
      if (flush) state <= IDLE;
      else if (pop) begin
        ir <= instrucao_fila;
        state <= HOLD;
      end else if (done) state <= IDLE;
    end
endmodule

// File: tb/tb_unidade_despacho.sv
// tb_unidade_despacho: random and directed stimulus checked against a queue-level issue model
module tb_unidade_despacho;
  logic clk = 0, rst_n = 0, flush = 0, empty = 1;
  logic [15:0] instrucao_fila = 0;
  logic [2:0] busy_add = 0;
  logic [1:0] busy_mul = 0, busy_mem = 0;
  logic pop, issue_valid, invalid_op;
  logic [1:0] issue_class;
  logic [3:0] issue_sel;
  logic [15:0] issue_instr, issued_count;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] q[$];
  bit held, last_v, m_inv;
  logic [15:0] hi, m_cnt;
  int last_c, last_i;

  unidade_despacho dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .empty(empty), .instrucao_fila(instrucao_fila),
    .pop(pop), .busy_add(busy_add), .busy_mul(busy_mul), .busy_mem(busy_mem),
    .issue_valid(issue_valid), .issue_class(issue_class), .issue_sel(issue_sel),
    .issue_instr(issue_instr), .invalid_op(invalid_op), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cls_of(logic [15:0] x);
    case (x[15:12])
      4'h0, 4'h1: return 0;
      4'h2: return 1;
      4'h3, 4'h4: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit busy_of(int c, int i);
    return c == 0 ? busy_add[i] : c == 1 ? busy_mul[i] : busy_mem[i];
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [3:0] op = $urandom_range(0, 9) < 8 ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
    return {op, 12'($urandom)};
  endfunction

  task automatic step(bit fl, bit hide, logic [2:0] ba, logic [1:0] bm, logic [1:0] bx);
    bit v = 0, drop = 0, ep;
    int c = 3, si = 0;
    logic [3:0] es;
    @(negedge clk);
    flush = fl; busy_add = ba; busy_mul = bm; busy_mem = bx;
    empty = hide || q.size() == 0;
    instrucao_fila = empty ? 16'($urandom) : q[0];
    #1;
    if (held) c = cls_of(hi);
    if (held && !fl) begin
      if (c == 3) drop = 1;
      else
        for (int i = 0; i < (c == 0 ? 3 : 2); i++)
          if (!v && !busy_of(c, i) && !(last_v && last_c == c && last_i == i)) begin
            v = 1;
            si = i;
          end
    end
    es = v ? 4'(1 << si) : 4'd0;
    ep = !empty && !fl && (!held || v || drop);
    chk("pop", pop, ep);
    chk("issue_valid", issue_valid, v);
    chk("issue_sel", issue_sel, es);
    if (held && c != 3) chk("issue_class", issue_class, c);
    if (v) chk("issue_instr", issue_instr, hi);
    chk("invalid_op", invalid_op, m_inv);
    chk("issued_count", issued_count, m_cnt);
    m_cnt += 16'(v);
    m_inv |= drop;
    last_v = v; last_c = c; last_i = si;
    if (fl) held = 0;
    else if (ep) begin
      held = 1;
      hi = q.pop_front();
    end else if (v || drop) held = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_pop", pop, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_sel", issue_sel, 0);
    chk("rst_issue_class", issue_class, 0);
    chk("rst_issue_instr", issue_instr, 0);
    chk("rst_invalid_op", invalid_op, 0);
    chk("rst_issued_count", issued_count, 0);
    q.delete();
    held = 0; last_v = 0; m_inv = 0; m_cnt = 0;
    @(negedge clk);
    empty = 1;
    rst_n = 1;
  endtask

  initial begin
    flush = 0;
    empty = 0;
    instrucao_fila = 16'h0123;
    do_reset();
    repeat (3) step(0, 0, 0, 0, 0);
    q = {16'h0123, 16'h2456, 16'h3789};
    repeat (5) step(0, 0, 0, 0, 0);
    chk("three_issued", issued_count, 3);
    q.push_back(16'h0aaa);
    step(0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 3'b111, 0, 0);
    step(0, 0, 3'b101, 0, 0);
    q = {16'h0001, 16'h1002};
    repeat (4) step(0, 0, 0, 0, 0);
    q = {16'hf000, 16'h1abc};
    repeat (4) step(0, 0, 0, 0, 0);
    chk("sticky_invalid", invalid_op, 1);
    q = {16'h0111, 16'h0222};
    step(0, 0, 0, 0, 0);
    step(0, 0, 3'b111, 0, 0);
    step(1, 0, 3'b111, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      if (q.size() < 4 && $urandom_range(0, 2) != 0) q.push_back(rand_instr());
      step($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
           3'($urandom), 2'($urandom), 2'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
